// File: rtl/connect4_board.sv
//==============================================================================
// Module      : connect4_board
// Description : Connect-4 board state. Accepts column drops over valid/ready,
//               lands each piece on the column height, alternates players and
//               publishes the packed 2-bit-per-cell board.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module connect4_board #(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     drop_valid,
  input  logic [2:0]               drop_col,
  input  logic                     lock,
  output logic                     drop_ready,
  output logic                     move_done,
  output logic                     move_illegal,
  output logic [2:0]               last_row,
  output logic [2:0]               last_col,
  output logic [1:0]               current_player,
  output logic [5:0]               move_count,
  output logic                     board_full,
  output logic [2*COLS*ROWS-1:0]   board
);

  localparam int CELLS = COLS * ROWS;
  localparam int BIT_W = $clog2(2 * CELLS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    PLACE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       col_q;
  logic [2:0]       heights [COLS];
  logic             col_ok;
  logic             col_full;
  logic [2:0]       col_height;
  logic [BIT_W-1:0] cell_bit;

  // Out-of-range columns read a height of zero; they are rejected anyway.
  always_comb begin
    col_ok     = (int'(col_q) < COLS);
    col_height = col_ok ? heights[col_q] : 3'd0;
    col_full   = (int'(col_height) == ROWS);
    cell_bit   = BIT_W'(2 * (int'(col_height) * COLS + int'(col_q)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    drop_ready = 1'b0;
    case (state)
      IDLE: begin
        drop_ready = !lock;
        if (drop_valid && !lock) begin
          state_nxt = CHECK;
        end
      end
      CHECK:   state_nxt = (!col_ok || col_full) ? IDLE : PLACE;
      PLACE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      board          <= '0;
      for (int i = 0; i < COLS; i++) begin
        heights[i] <= 3'd0;
      end
      col_q          <= 3'd0;
      move_count     <= 6'd0;
      current_player <= 2'b01;
      last_row       <= 3'd0;
      last_col       <= 3'd0;
      move_done      <= 1'b0;
      move_illegal   <= 1'b0;
      board_full     <= 1'b0;
    end else begin
      move_done    <= 1'b0;
      move_illegal <= 1'b0;

      if (state == IDLE && drop_valid && drop_ready) begin
        col_q <= drop_col;
      end

      if (state == CHECK && (!col_ok || col_full)) begin
        move_illegal <= 1'b1;
      end

      // CHECK has already guaranteed the column is in range and not full.
      if (state == PLACE) begin
        board[cell_bit +: 2] <= current_player;
        last_row             <= col_height;
        last_col             <= col_q;
        heights[col_q]       <= col_height + 3'd1;
        move_count           <= move_count + 6'd1;
        current_player       <= ~current_player;
        board_full           <= ((move_count + 6'd1) == 6'(CELLS));
        move_done            <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_connect4_board.sv
//==============================================================================
// Module      : tb_connect4_board
// Description : Self-checking bench for connect4_board against a cell-array
//               reference model with randomized column drops.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_connect4_board;

  localparam int COLS  = 7;
  localparam int ROWS  = 6;
  localparam int CELLS = COLS * ROWS;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   drop_valid = 1'b0;
  logic [2:0]             drop_col = 3'd0;
  logic                   lock = 1'b0;
  logic                   drop_ready;
  logic                   move_done;
  logic                   move_illegal;
  logic [2:0]             last_row;
  logic [2:0]             last_col;
  logic [1:0]             current_player;
  logic [5:0]             move_count;
  logic                   board_full;
  logic [2*CELLS-1:0]     board;

  int checks   = 0;
  int failures = 0;

  // Reference model: cell grid, column fill levels, player, counters.
  int         mh [COLS];
  logic [1:0] mcell [ROWS][COLS];
  logic [1:0] mplayer;
  int         mcount;
  int         mlr;
  int         mlc;

  connect4_board #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clock          (clock),
    .reset          (reset),
    .drop_valid     (drop_valid),
    .drop_col       (drop_col),
    .lock           (lock),
    .drop_ready     (drop_ready),
    .move_done      (move_done),
    .move_illegal   (move_illegal),
    .last_row       (last_row),
    .last_col       (last_col),
    .current_player (current_player),
    .move_count     (move_count),
    .board_full     (board_full),
    .board          (board)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int c = 0; c < COLS; c++) begin
      mh[c] = 0;
      for (int r = 0; r < ROWS; r++) mcell[r][c] = 2'b00;
    end
    mplayer = 2'b01;
    mcount  = 0;
    mlr     = 0;
    mlc     = 0;
  endtask

  function automatic logic [2*CELLS-1:0] model_board();
    logic [2*CELLS-1:0] b;
    b = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        b[2*(r*COLS+c) +: 2] = mcell[r][c];
    return b;
  endfunction

  // exp_kind: 1 = legal placement, 2 = rejected
  task automatic model_move(input int col, output int exp_kind);
    if (col >= COLS || mh[col] >= ROWS) begin
      exp_kind = 2;
    end else begin
      mcell[mh[col]][col] = mplayer;
      mlr = mh[col];
      mlc = col;
      mh[col]++;
      mcount++;
      mplayer = (mplayer == 2'b01) ? 2'b10 : 2'b01;
      exp_kind = 1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; drop_valid = 1'b0; lock = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // Performs one handshake and reports which pulse appeared, how many
  // negedges after the handshake edge, and drop_ready in the pulse cycle.
  // kind = -1 if never accepted, 0 if no pulse seen.
  task automatic do_drop(input int col, input logic lock_after,
                         output int kind, output int lat, output logic rdy);
    int w;
    kind = 0; lat = 0; rdy = 1'b0;
    @(negedge clock);
    drop_valid = 1'b1;
    drop_col   = 3'(col);
    w = 0;
    while (!drop_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (!drop_ready) begin
      kind = -1;
      drop_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    drop_valid = 1'b0;
    if (lock_after) lock = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      if (move_done || move_illegal) begin
        kind = (move_done && move_illegal) ? 3 : (move_done ? 1 : 2);
        lat  = i;
        rdy  = drop_ready;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (board !== '0) begin failures++; $display("FAIL reset_board got=%h exp=0", board); end
    checks++; if (current_player !== 2'b01) begin failures++; $display("FAIL reset_player got=%b exp=01", current_player); end
    checks++; if (move_count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", move_count); end
    checks++; if (board_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", board_full); end
    checks++; if ({last_row, last_col} !== 6'd0) begin failures++; $display("FAIL reset_last got=%0d,%0d exp=0,0", last_row, last_col); end
    checks++; if ({move_done, move_illegal} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {move_done, move_illegal}); end
    checks++; if (drop_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", drop_ready); end
  endtask

  task automatic test_first_drop();
    int k, l, ek; logic rdy;
    do_drop(3, 1'b0, k, l, rdy);
    model_move(3, ek);
    checks++; if (k !== 1 || l !== 3) begin failures++; $display("FAIL first_pulse got kind=%0d lat=%0d exp kind=1 lat=3", k, l); end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL first_ready got=%b exp=1", rdy); end
    checks++; if (board[7:6] !== 2'b01) begin failures++; $display("FAIL first_cell got=%b exp=01", board[7:6]); end
    checks++; if (board !== model_board()) begin failures++; $display("FAIL first_board got=%h exp=%h", board, model_board()); end
    checks++; if (last_row !== 3'd0 || last_col !== 3'd3) begin failures++; $display("FAIL first_last got=%0d,%0d exp=0,3", last_row, last_col); end
    checks++; if (current_player !== 2'b10) begin failures++; $display("FAIL first_player got=%b exp=10", current_player); end
    checks++; if (move_count !== 6'd1) begin failures++; $display("FAIL first_count got=%0d exp=1", move_count); end
    @(negedge clock);
    checks++; if (move_done !== 1'b0) begin failures++; $display("FAIL first_single_pulse got=%b exp=0", move_done); end
  endtask

  task automatic test_fill_column();
    int k, l, ek; logic rdy;
    logic [1:0] exp_cell;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      do_drop(0, 1'b0, k, l, rdy);
      model_move(0, ek);
      checks++;
      if (k !== ek || l !== ((ek == 1) ? 3 : 2)) begin
        failures++;
        $display("FAIL col0_drop%0d got kind=%0d lat=%0d exp kind=%0d", i, k, l, ek);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      exp_cell = (r % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (board[2*(r*COLS) +: 2] !== exp_cell) begin
        failures++;
        $display("FAIL col0_row%0d got=%b exp=%b", r, board[2*(r*COLS) +: 2], exp_cell);
      end
    end
    checks++; if (current_player !== 2'b01) begin failures++; $display("FAIL col0_player got=%b exp=01", current_player); end
    checks++; if (move_count !== 6'd6) begin failures++; $display("FAIL col0_count got=%0d exp=6", move_count); end
    checks++; if (board !== model_board()) begin failures++; $display("FAIL col0_board got=%h exp=%h", board, model_board()); end
  endtask

  task automatic test_out_of_range();
    int k, l, ek; logic rdy;
    logic [2*CELLS-1:0] snap;
    snap = board;
    do_drop(7, 1'b0, k, l, rdy);
    model_move(7, ek);
    checks++; if (k !== 2 || l !== 2) begin failures++; $display("FAIL oor_pulse got kind=%0d lat=%0d exp kind=2 lat=2", k, l); end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL oor_ready got=%b exp=1", rdy); end
    checks++; if (board !== snap || move_count !== 6'd6 || current_player !== 2'b01) begin
      failures++; $display("FAIL oor_state got count=%0d player=%b exp count=6 player=01", move_count, current_player);
    end
    @(negedge clock);
    checks++; if (move_illegal !== 1'b0) begin failures++; $display("FAIL oor_single_pulse got=%b exp=0", move_illegal); end
  endtask

  task automatic test_lock();
    int k, l, ek; logic rdy;
    apply_reset();
    lock = 1'b1; drop_valid = 1'b1; drop_col = 3'd2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if ({drop_ready, move_done, move_illegal} !== 3'b000) begin
        failures++;
        $display("FAIL lock_hold cyc%0d got ready/done/ill=%b exp=000", i, {drop_ready, move_done, move_illegal});
      end
    end
    lock = 1'b0; drop_valid = 1'b0;
    checks++; if (move_count !== 6'd0) begin failures++; $display("FAIL lock_count got=%0d exp=0", move_count); end
    do_drop(2, 1'b1, k, l, rdy);
    model_move(2, ek);
    checks++; if (k !== 1 || l !== 3) begin failures++; $display("FAIL lock_inflight got kind=%0d lat=%0d exp kind=1 lat=3", k, l); end
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL lock_ready got=%b exp=0", rdy); end
    checks++; if (board !== model_board()) begin failures++; $display("FAIL lock_board got=%h exp=%h", board, model_board()); end
    lock = 1'b0;
  endtask

  task automatic test_reset_in_place();
    @(negedge clock);
    drop_valid = 1'b1; drop_col = 3'd4;
    checks++; if (drop_ready !== 1'b1) begin failures++; $display("FAIL rip_ready got=%b exp=1", drop_ready); end
    @(posedge clock); #1;
    drop_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    checks++; if (move_done !== 1'b0) begin failures++; $display("FAIL rip_done got=%b exp=0", move_done); end
    checks++; if (board !== '0) begin failures++; $display("FAIL rip_board got=%h exp=0", board); end
    checks++; if (current_player !== 2'b01 || move_count !== 6'd0) begin
      failures++; $display("FAIL rip_state got player=%b count=%0d exp 01,0", current_player, move_count);
    end
    @(negedge clock);
    checks++; if (move_done !== 1'b0) begin failures++; $display("FAIL rip_late_done got=%b exp=0", move_done); end
  endtask

  task automatic test_random_fill();
    int k, l, ek, col, it, n;
    int legal [$];
    logic rdy;
    apply_reset();
    it = 0;
    while (mcount < CELLS && it < 600) begin
      if ($urandom_range(0, 3) == 0) begin
        col = int'($urandom_range(0, 7));
      end else begin
        legal.delete();
        for (int c = 0; c < COLS; c++) if (mh[c] < ROWS) legal.push_back(c);
        n = legal.size();
        col = legal[$urandom_range(0, n - 1)];
      end
      do_drop(col, 1'b0, k, l, rdy);
      model_move(col, ek);
      checks++;
      if (k !== ek || l !== ((ek == 1) ? 3 : 2) || rdy !== 1'b1) begin
        failures++;
        $display("FAIL rand_pulse it=%0d col=%0d got kind=%0d lat=%0d rdy=%b exp kind=%0d", it, col, k, l, rdy, ek);
      end
      checks++;
      if (board !== model_board() || current_player !== mplayer || move_count !== 6'(mcount)) begin
        failures++;
        $display("FAIL rand_state it=%0d got player=%b count=%0d exp player=%b count=%0d", it, current_player, move_count, mplayer, mcount);
      end
      checks++;
      if (last_row !== 3'(mlr) || last_col !== 3'(mlc) || board_full !== (mcount == CELLS)) begin
        failures++;
        $display("FAIL rand_last it=%0d got %0d,%0d full=%b exp %0d,%0d", it, last_row, last_col, board_full, mlr, mlc);
      end
      @(negedge clock);
      checks++;
      if ({move_done, move_illegal} !== 2'b00) begin
        failures++; $display("FAIL rand_pulse_width it=%0d got=%b exp=00", it, {move_done, move_illegal});
      end
      it++;
    end
    checks++; if (move_count !== 6'd42 || board_full !== 1'b1) begin
      failures++; $display("FAIL full_state got count=%0d full=%b exp 42,1", move_count, board_full);
    end
  endtask

  task automatic test_full_reject();
    int k, l, ek, col; logic rdy;
    for (int i = 0; i < 3; i++) begin
      col = int'($urandom_range(0, COLS - 1));
      do_drop(col, 1'b0, k, l, rdy);
      model_move(col, ek);
      checks++;
      if (k !== 2 || ek !== 2 || l !== 2) begin
        failures++; $display("FAIL full_reject col=%0d got kind=%0d lat=%0d exp kind=2 lat=2", col, k, l);
      end
      checks++;
      if (board !== model_board() || move_count !== 6'd42 || board_full !== 1'b1) begin
        failures++; $display("FAIL full_unchanged col=%0d got count=%0d full=%b", col, move_count, board_full);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_drop();
    test_fill_column();
    test_out_of_range();
    test_lock();
    test_reset_in_place();
    test_random_fill();
    test_full_reject();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/connect4_board.md
# connect4_board

Authoritative game-board state for the Connect-4 datapath. It accepts column-drop requests over a valid/ready handshake and resolves each piece's landing row from per-column height counters. It rejects full or out-of-range columns, alternates players, and publishes the packed board vector. The win-line extraction / sequence-recognition stage downstream consumes this vector, using the same 2-bit cell code.

## Interface
- COLS, 7, board columns
- ROWS, 6, board rows
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- drop_valid  in  1  drop request present
- drop_col  in  3  requested column, 0 = leftmost
- lock  in  1  freeze input (driven high once a winner is declared); blocks new requests
- drop_ready  out  1  block can accept a request
- move_done  out  1  one-cycle pulse: piece placed
- move_illegal  out  1  one-cycle pulse: request rejected
- last_row  out  3  landing row of the most recent legal move
- last_col  out  3  column of the most recent legal move
- current_player  out  2  player to move: 01 red, 10 yellow
- move_count  out  6  legal moves made, 0..COLS*ROWS
- board_full  out  1  move_count == COLS*ROWS
- board  out  2*COLS*ROWS  packed board; cell (r,c) at bits [2*(r*COLS+c)+1 : 2*(r*COLS+c)], r=0 bottom; 00 empty, 01 red, 10 yellow

## Operation
- Reset values:
  - board = 0, all heights = 0, move_count = 0
  - current_player = 01 (red moves first)
  - last_row = 0, last_col = 0
  - move_done = 0, move_illegal = 0, board_full = 0
  - state = IDLE
- Internal state: per-column height counters, 3 bits each, range 0..ROWS.
- FSM states:
  - IDLE: drop_ready = !lock (combinational). A handshake (drop_valid & drop_ready at an edge) captures drop_col into col_q and moves to CHECK. Without a handshake, stay in IDLE.
  - CHECK: if col_q >= COLS or height[col_q] == ROWS, the move is illegal: pulse move_illegal and return to IDLE. Otherwise go to PLACE.
  - PLACE: all of the following happen on the leaving edge, then return to IDLE:
    - write current_player into cell (height[col_q], col_q)
    - last_row <= height[col_q], last_col <= col_q
    - height[col_q] increments
    - move_count increments
    - current_player toggles 01<->10
    - move_done pulses
- drop_ready is 0 in CHECK and PLACE. Requests presented then are not accepted; the requester holds drop_valid.
- Illegal moves change nothing except the pulse. The player does not toggle and the same player retries.
- lock rising while in CHECK or PLACE: the in-flight move completes normally. lock only gates acceptance in IDLE.
- board_full: all columns are full, so every subsequent request resolves as illegal. There is no special case beyond this.
- Cells are written only with 01 or 10; a non-empty cell is never overwritten.
- Height and count arithmetic never wraps. Saturation is structural, enforced by the CHECK rejection.

## Timing
- Handshake at edge E0.
  - Illegal: move_illegal is high for the cycle after E1, and drop_ready is high again in that same cycle (if lock=0).
  - Legal: board, last_*, move_count and current_player update at E2. move_done is high for the cycle after E2, and drop_ready is high in that cycle.
- Throughput: one legal move per 3 cycles, one illegal per 2 cycles.
- board, current_player, move_count and board_full are registered outputs. They change only at the PLACE exit edge or at reset.
- Reset has priority over everything. Reset asserted in CHECK or PLACE aborts the move: no board write, no pulse, and all outputs return to reset values at the next edge.
- move_done and move_illegal are never high in the same cycle and are never high for two consecutive cycles from one request.

## Test plan
- Reset, then drop col 3 → after 3 edges: board bits[7:6] = 01, last_row = 0, last_col = 3, current_player = 10, move_count = 1, one move_done pulse.
- Six alternating drops into col 0, then a seventh → rows 0..5 of col 0 = 01,10,01,10,01,10; the seventh gives move_illegal, current_player stays 01, move_count = 6, board unchanged.
- drop_col = 7 → move_illegal pulse after 2 edges, no state change, drop_ready high in the pulse cycle.
- Hold lock=1 with drop_valid=1 → drop_ready = 0 and no pulses. Raise lock during CHECK of a legal move → that move still completes with move_done.
- Assert reset in the PLACE cycle → no move_done, board = 0, current_player = 01, move_count = 0 at the next edge.
- Fill all 42 cells legally → board_full = 1, move_count = 42, and a 43rd request to any column gives move_illegal.
